// File: rtl/mpc_mac_acc_21s_8ns_if.sv
// ---------------------------------------------------------------------------
// mpc_mac_acc_21s_8ns_if
//
// Purpose:
//    Bundles every handshake and data signal of the MPC dot-product stage:
//    the operand stream, the external multiplier port and the result stream.
//
// Port summary (signal : direction seen from the stage, i.e. the slave):
//    in_valid  : in   operand pair valid
//    in_ready  : out  stage can accept an operand pair
//    in_a      : in   operand A, 21-bit signed
//    in_b      : in   operand B, 8-bit unsigned
//    in_last   : in   final term of the current vector
//    mul_ce    : out  multiplier clock enable
//    mul_din0  : out  multiplier operand 0 (follows in_a)
//    mul_din1  : out  multiplier operand 1 (follows in_b)
//    mul_dout  : in   30-bit signed product from the multiplier
//    res_valid : out  result valid
//    res_ready : in   consumer accepts the result
//    res_data  : out  OUT_W-bit signed scaled and saturated dot product
//    res_ovf   : out  saturation happened somewhere in this vector
//
// Modports:
//    slave  - the dot-product stage itself
//    master - the environment (operand source, multiplier, result sink)
// ---------------------------------------------------------------------------
interface mpc_mac_acc_21s_8ns_if #(
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [20:0]      in_a;
   logic [7:0]       in_b;
   logic             in_last;
   logic             mul_ce;
   logic [20:0]      mul_din0;
   logic [7:0]       mul_din1;
   logic [29:0]      mul_dout;
   logic             res_valid;
   logic             res_ready;
   logic [OUT_W-1:0] res_data;
   logic             res_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_last, mul_dout, res_ready,
      output in_ready, mul_ce, mul_din0, mul_din1, res_valid, res_data, res_ovf
   );

   modport master (
      output in_valid, in_a, in_b, in_last, mul_dout, res_ready,
      input  in_ready, mul_ce, mul_din0, mul_din1, res_valid, res_data, res_ovf
   );
endinterface

// File: rtl/mpc_mac_acc_21s_8ns.sv
// ---------------------------------------------------------------------------
// mpc_mac_acc_21s_8ns
//
// Purpose:
//    Dot-product stage wrapped around the external 21s x 8ns -> 30-bit
//    pipelined multiplier of the implicit-MPC datapath. Operand pairs are
//    forwarded to the multiplier, their valid/last flags ride a delay line
//    matched to the multiplier latency, products are accumulated with
//    saturation, and one scaled, saturated result is emitted per vector.
//
// Ports:
//    clk     : clock
//    reset   : synchronous, active-high reset
//    io_bus  : mpc_mac_acc_21s_8ns_if.slave (operand stream, multiplier
//              port, result stream)
//
// Parameters:
//    MUL_LAT    : multiplier latency in ce-qualified cycles
//    ACC_W      : signed accumulator width
//    OUT_W      : signed result width (must match the interface OUT_W)
//    FRAC_SHIFT : right shift applied to the final sum, >= 1
//
// Configuration macro:
//    MPC_ACC_ROUND_EN - when defined, the final scale adds 2^(FRAC_SHIFT-1)
//                       before the shift (round half up); otherwise the
//                       shift truncates toward minus infinity.
// ---------------------------------------------------------------------------
module mpc_mac_acc_21s_8ns #(
   parameter int MUL_LAT    = 3,
   parameter int ACC_W      = 40,
   parameter int OUT_W      = 32,
   parameter int FRAC_SHIFT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   mpc_mac_acc_21s_8ns_if.slave  io_bus
);

   localparam int PROD_W = 30;
   localparam int SUM_W  = ACC_W + 1;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

`ifdef MPC_ACC_ROUND_EN
   localparam logic signed [SUM_W-1:0] ROUND_ADD = {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
`else
   localparam logic signed [SUM_W-1:0] ROUND_ADD = '0;
`endif

   logic                     w_stall;
   logic                     w_adv;
   logic                     w_tailValid;
   logic                     w_tailLast;
   logic                     w_accOvf;
   logic                     w_outOvf;
   logic                     w_stickyNext;
   logic [MUL_LAT-1:0]       r_validLine;
   logic [MUL_LAT-1:0]       r_lastLine;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [ACC_W-1:0]  w_accSat;
   logic                     r_first;
   logic                     r_sticky;
   logic                     r_resValid;
   logic                     r_resOvf;
   logic signed [OUT_W-1:0]  r_resData;
   logic signed [OUT_W-1:0]  w_outSat;
   logic signed [SUM_W-1:0]  w_accBase;
   logic signed [SUM_W-1:0]  w_prodExt;
   logic signed [SUM_W-1:0]  w_sumWide;
   logic signed [SUM_W-1:0]  w_scaleIn;
   logic signed [SUM_W-1:0]  w_shifted;
   logic [SUM_W-OUT_W:0]     w_outHigh;

   // A result that the consumer is not taking freezes the whole pipe:
   // operand intake, the multiplier (via its clock enable) and the delay
   // line all hold together so no product is lost or duplicated.
   assign w_stall = r_resValid & ~io_bus.res_ready;
   assign w_adv   = ~w_stall;

   assign io_bus.in_ready = w_adv;
   assign io_bus.mul_ce   = w_adv;
   assign io_bus.mul_din0 = io_bus.in_a;
   assign io_bus.mul_din1 = io_bus.in_b;

   // The tail of the delay line lines up with mul_dout; a tail term is only
   // consumed on a cycle where the pipe actually advances.
   assign w_tailValid = r_validLine[MUL_LAT-1] & w_adv;
   assign w_tailLast  = r_lastLine[MUL_LAT-1];

   // Accumulate one bit wider than the accumulator so overflow is visible as
   // a disagreement between the two top bits, then clamp to ACC_W limits.
   // The first term of a vector ignores whatever is left in r_acc.
   assign w_accBase    = r_first ? '0 : {r_acc[ACC_W-1], r_acc};
   assign w_prodExt    = {{(SUM_W-PROD_W){io_bus.mul_dout[PROD_W-1]}}, io_bus.mul_dout};
   assign w_sumWide    = w_accBase + w_prodExt;
   assign w_accOvf     = w_sumWide[SUM_W-1] ^ w_sumWide[SUM_W-2];
   assign w_accSat     = !w_accOvf ? w_sumWide[ACC_W-1:0]
                                   : (w_sumWide[SUM_W-1] ? ACC_MIN : ACC_MAX);
   assign w_stickyNext = r_sticky | w_accOvf;

   // Final scaling: optional rounding offset at ACC_W+1 bits (cannot wrap),
   // arithmetic shift (floor), then clamp to OUT_W. The result fits OUT_W
   // only if every bit from OUT_W-1 upward is a copy of the sign.
   assign w_scaleIn = {w_accSat[ACC_W-1], w_accSat} + ROUND_ADD;
   assign w_shifted = w_scaleIn >>> FRAC_SHIFT;
   assign w_outHigh = w_shifted[SUM_W-1:OUT_W-1];
   assign w_outOvf  = ~((&w_outHigh) | ~(|w_outHigh));
   assign w_outSat  = !w_outOvf ? w_shifted[OUT_W-1:0]
                                : (w_shifted[SUM_W-1] ? OUT_MIN : OUT_MAX);

   // Valid/last delay line matched to the multiplier latency. It shifts only
   // when the multiplier is enabled, so each flag stays glued to its product.
   // A last flag is only recorded together with a valid beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_validLine <= '0;
         r_lastLine  <= '0;
      end else if (w_adv) begin
         r_validLine[0] <= io_bus.in_valid;
         r_lastLine[0]  <= io_bus.in_valid & io_bus.in_last;
         for (int i = 1; i < MUL_LAT; i++) begin
            r_validLine[i] <= r_validLine[i-1];
            r_lastLine[i]  <= r_lastLine[i-1];
         end
      end
   end

   // Accumulator and result register. A non-last tail term updates the
   // running sum and sticky overflow; a last tail term publishes the scaled
   // result and rearms first/sticky for the next vector. The result valid
   // drops on a handshake unless a new completion lands in that same cycle,
   // in which case the new result replaces the old one with no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc      <= '0;
         r_first    <= 1'b1;
         r_sticky   <= 1'b0;
         r_resValid <= 1'b0;
         r_resData  <= '0;
         r_resOvf   <= 1'b0;
      end else begin
         if (r_resValid && io_bus.res_ready) begin
            r_resValid <= 1'b0;
         end
         if (w_tailValid) begin
            if (w_tailLast) begin
               r_resValid <= 1'b1;
               r_resData  <= w_outSat;
               r_resOvf   <= w_stickyNext | w_outOvf;
               r_first    <= 1'b1;
               r_sticky   <= 1'b0;
            end else begin
               r_acc      <= w_accSat;
               r_first    <= 1'b0;
               r_sticky   <= w_stickyNext;
            end
         end
      end
   end

   assign io_bus.res_valid = r_resValid;
   assign io_bus.res_data  = r_resData;
   assign io_bus.res_ovf   = r_resOvf;

endmodule

// File: tb/tb_mpc_mac_acc_21s_8ns.sv
// ---------------------------------------------------------------------------
// tb_mpc_mac_acc_21s_8ns
//
// Purpose:
//    Self-checking bench for mpc_mac_acc_21s_8ns. Provides a behavioural
//    pipelined multiplier on the mul_* port, drives directed and random
//    operand vectors, and compares every result against a scoreboard fed by
//    a plain-arithmetic dot-product model. The DUT is built with OUT_W=16
//    so output saturation is reachable with ordinary operands.
//
// Configuration macro:
//    MPC_ACC_ROUND_EN - selects the rounding expectations.
// ---------------------------------------------------------------------------
module tb_mpc_mac_acc_21s_8ns;

   localparam int MUL_LAT    = 3;
   localparam int ACC_W      = 40;
   localparam int OUT_W      = 16;
   localparam int FRAC_SHIFT = 8;

`ifdef MPC_ACC_ROUND_EN
   localparam longint T1_EXP = 7;
   localparam longint T2_EXP = -1;
   localparam longint T4_EXP = 2;
`else
   localparam longint T1_EXP = 6;
   localparam longint T2_EXP = -2;
   localparam longint T4_EXP = 2;
`endif

   logic   clk   = 1'b0;
   logic   reset = 1'b1;

   int     checkCount = 0;
   int     errorCount = 0;
   int     cycle      = 0;
   int     resCount   = 0;
   longint lastData   = 0;
   bit     lastOvf    = 1'b0;
   bit     randReady  = 1'b0;

   longint curVec[$];
   longint expData[$];
   bit     expOvf[$];
   int     hsCycles[$];

   logic [29:0] mulPipe [MUL_LAT];

   mpc_mac_acc_21s_8ns_if #(.OUT_W(OUT_W)) bus ();

   mpc_mac_acc_21s_8ns #(
      .MUL_LAT    (MUL_LAT),
      .ACC_W      (ACC_W),
      .OUT_W      (OUT_W),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus.slave)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Signed 21-bit times unsigned 8-bit, truncated to the 30-bit port.
   function automatic logic [29:0] mulModel(input logic [20:0] a, input logic [7:0] b);
      longint pa;
      longint pb;
      longint p;
      pa = longint'($signed(a));
      pb = longint'(b);
      p  = pa * pb;
      return p[29:0];
   endfunction

   // Behavioural stand-in for the external multiplier: MUL_LAT registers
   // that only move while mul_ce is high.
   always @(posedge clk) begin
      if (bus.mul_ce) begin
         mulPipe[0] <= mulModel(bus.mul_din0, bus.mul_din1);
         for (int i = 1; i < MUL_LAT; i++) begin
            mulPipe[i] <= mulPipe[i-1];
         end
      end
   end

   assign bus.mul_dout = mulPipe[MUL_LAT-1];

   // Dot-product reference: running sum clamped to the accumulator range,
   // then optional rounding, floor division by 2^FRAC_SHIFT and a clamp to
   // the output range. Any clamp marks the vector as overflowed.
   function automatic void modelVector(input longint prods[$], output longint resData, output bit resOvf);
      longint accMax;
      longint accMin;
      longint outMax;
      longint outMin;
      longint sum;
      longint scaled;
      accMax = (longint'(1) <<< (ACC_W-1)) - 1;
      accMin = -(longint'(1) <<< (ACC_W-1));
      outMax = (longint'(1) <<< (OUT_W-1)) - 1;
      outMin = -(longint'(1) <<< (OUT_W-1));
      sum    = 0;
      resOvf = 1'b0;
      foreach (prods[i]) begin
         sum = sum + prods[i];
         if (sum > accMax) begin
            sum    = accMax;
            resOvf = 1'b1;
         end else if (sum < accMin) begin
            sum    = accMin;
            resOvf = 1'b1;
         end
      end
      scaled = sum;
`ifdef MPC_ACC_ROUND_EN
      scaled = scaled + (longint'(1) <<< (FRAC_SHIFT-1));
`endif
      scaled = scaled >>> FRAC_SHIFT;
      if (scaled > outMax) begin
         scaled = outMax;
         resOvf = 1'b1;
      end else if (scaled < outMin) begin
         scaled = outMin;
         resOvf = 1'b1;
      end
      resData = scaled;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Monitor/scoreboard, sampling on the falling edge. Accepted beats are
   // gathered per vector; a last beat turns the vector into an expected
   // result. Result handshakes are checked in order against that queue.
   // Reset discards everything in flight.
   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         if (reset) begin
            curVec.delete();
            expData.delete();
            expOvf.delete();
         end else begin
            if (bus.res_valid && bus.res_ready) begin
               checkOutput("sb_pending", longint'(expData.size() > 0), 1);
               if (expData.size() > 0) begin
                  checkOutput("res_data", longint'($signed(bus.res_data)), expData.pop_front());
                  checkOutput("res_ovf", longint'(bus.res_ovf), longint'(expOvf.pop_front()));
               end
               lastData = longint'($signed(bus.res_data));
               lastOvf  = bus.res_ovf;
               resCount++;
               hsCycles.push_back(cycle);
            end
            if (bus.in_valid && bus.in_ready) begin
               longint d;
               bit     o;
               checkOutput("mul_din0", longint'($signed(bus.mul_din0)), longint'($signed(bus.in_a)));
               checkOutput("mul_din1", longint'(bus.mul_din1), longint'(bus.in_b));
               curVec.push_back(longint'($signed(bus.in_a)) * longint'(bus.in_b));
               if (bus.in_last) begin
                  modelVector(curVec, d, o);
                  expData.push_back(d);
                  expOvf.push_back(o);
                  curVec.delete();
               end
            end
         end
      end
   end

   // Random consumer back-pressure while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReady) begin
            bus.res_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Present one operand pair and hold it until the stage accepts it;
   // returns just after the accepting clock edge with in_valid still high.
   task automatic applyStimulus(input int a, input int b, input bit last);
      bit accepted;
      accepted     = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a     = 21'(a);
      bus.in_b     = 8'(b);
      bus.in_last  = last;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      checkOutput("accept", longint'(accepted), 1);
   endtask

   task automatic idleCycles(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic doReset(input int n);
      bus.in_valid = 1'b0;
      reset        = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      reset        = 1'b0;
   endtask

   task automatic waitResults(input int target);
      for (int i = 0; i < 6000 && resCount < target; i++) @(negedge clk);
      @(negedge clk);
      checkOutput("results_arrived", longint'(resCount >= target), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetState(input string tag);
      @(negedge clk);
      checkOutput({tag, "_res_valid"}, longint'(bus.res_valid), 0);
      checkOutput({tag, "_res_data"}, longint'($signed(bus.res_data)), 0);
      checkOutput({tag, "_res_ovf"}, longint'(bus.res_ovf), 0);
      checkOutput({tag, "_in_ready"}, longint'(bus.in_ready), 1);
      @(posedge clk);
      #1;
   endtask

   // Global time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed scenarios, random traffic, saturation.
   initial begin
      int base;
      int lat;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_last   = 1'b0;
      bus.res_ready = 1'b1;

      doReset(3);
      checkResetState("reset");

      // Three-term vector and its completion latency.
      applyStimulus(100, 2, 1'b0);
      applyStimulus(-50, 4, 1'b0);
      applyStimulus(7, 255, 1'b1);
      bus.in_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (lat == 0 && bus.res_valid) lat = n;
      end
      checkOutput("t1_latency", lat, MUL_LAT + 1);
      checkOutput("t1_data", lastData, T1_EXP);
      checkOutput("t1_ovf", longint'(lastOvf), 0);
      @(posedge clk);
      #1;

      // Single-term negative vector.
      base = resCount;
      applyStimulus(-300, 1, 1'b1);
      idleCycles(0);
      waitResults(base + 1);
      checkOutput("t2_data", lastData, T2_EXP);

      // Output saturation, then a clean vector clears the overflow flag.
      base = resCount;
      applyStimulus(-1048576, 255, 1'b1);
      idleCycles(0);
      waitResults(base + 1);
      checkOutput("t3_data", lastData, -32768);
      checkOutput("t3_ovf", longint'(lastOvf), 1);
      applyStimulus(1, 1, 1'b1);
      idleCycles(0);
      waitResults(base + 2);
      checkOutput("t3_next_ovf", longint'(lastOvf), 0);
      checkOutput("t3_next_data", lastData, 0);

      // Back-pressure with a second vector in flight.
      base = resCount;
      bus.res_ready = 1'b0;
      applyStimulus(10, 3, 1'b0);
      applyStimulus(20, 5, 1'b1);
      applyStimulus(-7, 9, 1'b0);
      applyStimulus(3, 200, 1'b1);
      bus.in_valid = 1'b0;
      @(posedge clk);
      repeat (5) begin
         @(negedge clk);
         checkOutput("t4_res_valid", longint'(bus.res_valid), 1);
         checkOutput("t4_in_ready", longint'(bus.in_ready), 0);
         checkOutput("t4_mul_ce", longint'(bus.mul_ce), 0);
      end
      checkOutput("t4_held", resCount, base);
      @(posedge clk);
      #1;
      bus.res_ready = 1'b1;
      waitResults(base + 2);
      checkOutput("t4_second", lastData, T4_EXP);

      // Continuous two-term vectors: one result every two cycles.
      base = resCount;
      hsCycles.delete();
      for (int v = 0; v < 6; v++) begin
         applyStimulus(v * 37 - 90, 3 + v, 1'b0);
         applyStimulus(v * 11 + 5, 200 - v, 1'b1);
      end
      idleCycles(0);
      waitResults(base + 6);
      checkOutput("t5_count", hsCycles.size(), 6);
      for (int i = 1; i < hsCycles.size(); i++) begin
         checkOutput("t5_spacing", hsCycles[i] - hsCycles[i-1], 2);
      end

      // Reset in the middle of a vector leaves no residue.
      applyStimulus(1000, 100, 1'b0);
      applyStimulus(2000, 200, 1'b0);
      doReset(1);
      checkResetState("t6_reset");
      base = resCount;
      applyStimulus(512, 1, 1'b1);
      idleCycles(0);
      waitResults(base + 1);
      checkOutput("t6_data", lastData, 2);
      checkOutput("t6_ovf", longint'(lastOvf), 0);

      // Random vectors with random gaps and random consumer back-pressure.
      randReady = 1'b1;
      for (int v = 0; v < 40; v++) begin
         int len;
         len = int'($urandom_range(1, 6));
         for (int k = 0; k < len; k++) begin
            int a;
            int b;
            if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 2097151)) - 1048576;
            else                           a = int'($urandom_range(0, 4000)) - 2000;
            b = int'($urandom_range(0, 255));
            applyStimulus(a, b, k == len - 1);
            if ($urandom_range(0, 4) == 0) idleCycles(1);
         end
      end
      bus.in_valid = 1'b0;
      randReady    = 1'b0;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 3000 && expData.size() != 0; i++) @(negedge clk);
      checkOutput("rand_drained", expData.size(), 0);
      @(posedge clk);
      #1;

      // Long vectors that drive the accumulator into its limits.
      base = resCount;
      for (int k = 0; k < 2100; k++) applyStimulus(-1048576, 255, k == 2099);
      idleCycles(0);
      waitResults(base + 1);
      checkOutput("sat_neg_data", lastData, -32768);
      checkOutput("sat_neg_ovf", longint'(lastOvf), 1);
      for (int k = 0; k < 2100; k++) applyStimulus(1048575, 255, k == 2099);
      idleCycles(0);
      waitResults(base + 2);
      checkOutput("sat_pos_data", lastData, 32767);
      checkOutput("sat_pos_ovf", longint'(lastOvf), 1);

      idleCycles(4);
      checkOutput("final_drained", expData.size(), 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
